// File: rtl/fp_pkg.sv
// Shared constants and types for the floating-point result path.
package fp_pkg;

  localparam int W     = 64;
  localparam int EXP_W = 11;
  localparam int MAN_W = 52;

  localparam int ZERO = 0;
  localparam int SUB  = 1;
  localparam int INF  = 2;
  localparam int NAN  = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 class decoder: {sign, exp, man} -> one-hot {nan, inf, subnormal, zero}.
module fp_classify
  import fp_pkg::*;
(
  input  logic             i_sign,
  input  logic [EXP_W-1:0] i_exp,
  input  logic [MAN_W-1:0] i_man,
  output logic [3:0]       o_class
);

  logic w_exp_zero;
  logic w_exp_ones;
  logic w_man_zero;
  logic w_unused_sign;

  // Class does not depend on the sign; both signed zeros are "zero".
  assign w_unused_sign = i_sign;
  assign w_exp_zero    = (i_exp == '0);
  assign w_exp_ones    = (i_exp == '1);
  assign w_man_zero    = (i_man == '0);

  always_comb begin
    o_class       = 4'b0000;
    o_class[ZERO] = w_exp_zero && w_man_zero;
    o_class[SUB]  = w_exp_zero && !w_man_zero;
    o_class[INF]  = w_exp_ones && w_man_zero;
    o_class[NAN]  = w_exp_ones && !w_man_zero;
  end

endmodule

// File: rtl/fp_add_result_stage.sv
// Two-entry skid buffer behind the FP adder with delivery counter.
// Define FP_RES_FLAGS_EN to build result classification, out_class and sticky_flags.
module fp_add_result_stage
  import fp_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_sum,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sum,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_class,
  input  logic             flags_clr,
  output logic [3:0]       sticky_flags,
  output logic [CNT_W-1:0] res_count
);

  state_t           r_state;
  logic [W-1:0]     r_head_sum;
  logic [W-1:0]     r_tail_sum;
  logic [TAG_W-1:0] r_head_tag;
  logic [TAG_W-1:0] r_tail_tag;
  logic [CNT_W-1:0] r_count;

  logic w_accept;
  logic w_deliver;
  logic w_head_from_in;
  logic w_head_from_tail;
  logic w_tail_from_in;

  // Ready comes only from registered state, so there is no out_ready -> in_ready path.
  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign w_accept  = in_valid && in_ready;
  assign w_deliver = out_valid && out_ready;

  assign w_head_from_in   = w_accept && ((r_state == EMPTY) || (r_state == ONE && w_deliver));
  assign w_tail_from_in   = w_accept && (r_state == ONE) && !w_deliver;
  assign w_head_from_tail = w_deliver && (r_state == FULL);

  assign out_sum   = r_head_sum;
  assign out_tag   = r_head_tag;
  assign res_count = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_head_sum <= '0;
      r_head_tag <= '0;
      r_count    <= '0;
    end else begin
      if (w_deliver) begin
        r_count <= r_count + CNT_W'(1);
      end
      if (w_head_from_in) begin
        r_head_sum <= in_sum;
        r_head_tag <= in_tag;
      end else if (w_head_from_tail) begin
        r_head_sum <= r_tail_sum;
        r_head_tag <= r_tail_tag;
      end
      if (w_tail_from_in) begin
        r_tail_sum <= in_sum;
        r_tail_tag <= in_tag;
      end
      case (r_state)
        EMPTY:   if (w_accept) r_state <= ONE;
        ONE: begin
          if (w_accept && !w_deliver) r_state <= FULL;
          else if (!w_accept && w_deliver) r_state <= EMPTY;
        end
        FULL:    if (w_deliver) r_state <= ONE;
        default: r_state <= EMPTY;
      endcase
    end
  end

`ifdef FP_RES_FLAGS_EN
  logic [3:0] w_in_class;
  logic [3:0] r_head_class;
  logic [3:0] r_tail_class;
  logic [3:0] r_sticky;

  fp_classify u_classify (
    .i_sign  (in_sum[W-1]),
    .i_exp   (in_sum[W-2 -: EXP_W]),
    .i_man   (in_sum[MAN_W-1:0]),
    .o_class (w_in_class)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head_class <= '0;
      r_sticky     <= '0;
    end else begin
      if (w_head_from_in)        r_head_class <= w_in_class;
      else if (w_head_from_tail) r_head_class <= r_tail_class;
      if (w_tail_from_in)        r_tail_class <= w_in_class;
      // An accept coinciding with a clear leaves only the new entry's class.
      if (w_accept)       r_sticky <= flags_clr ? w_in_class : (r_sticky | w_in_class);
      else if (flags_clr) r_sticky <= '0;
    end
  end

  assign out_class    = r_head_class;
  assign sticky_flags = r_sticky;
`else
  logic w_unused_flags_clr;

  assign w_unused_flags_clr = flags_clr;
  assign out_class          = 4'b0000;
  assign sticky_flags       = 4'b0000;
`endif

endmodule

// File: tb/tb_fp_add_result_stage.sv
// Self-checking bench for fp_add_result_stage against a queue-based reference model.
`timescale 1ns/1ps
module tb_fp_add_result_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, flags_clr;
  logic [63:0] in_sum, out_sum;
  logic [3:0]  in_tag, out_tag, out_class, sticky_flags;
  logic [15:0] res_count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [63:0] mq_sum[$];
  logic [3:0]  mq_tag[$];
  logic [15:0] m_count  = 16'd0;
  logic [3:0]  m_sticky = 4'd0;

  always #5 clk = ~clk;

  fp_add_result_stage #(.TAG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_tag(out_tag),
    .out_class(out_class), .flags_clr(flags_clr), .sticky_flags(sticky_flags),
    .res_count(res_count)
  );

  // IEEE-754 class from the exponent/mantissa rules; no classes exist without the flags feature.
  function automatic logic [3:0] ref_class(input logic [63:0] v);
    logic [3:0] c;
    c = 4'b0000;
    if (v[62:52] == 11'h7FF)   c = (v[51:0] != 52'd0) ? 4'b1000 : 4'b0100;
    else if (v[62:52] == 11'd0) c = (v[51:0] != 52'd0) ? 4'b0010 : 4'b0001;
`ifdef FP_RES_FLAGS_EN
    return c;
`else
    return c & 4'b0000;
`endif
  endfunction

  function automatic logic [63:0] rand_val();
    logic [51:0] m;
    logic        s;
    m = {$urandom, $urandom} | 52'd1;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0:       return {s, 11'd0, 52'd0};
      1:       return {s, 11'd0, m};
      2:       return {s, 11'h7FF, 52'd0};
      3:       return {s, 11'h7FF, m};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Advance one clock and apply the same handshake to the model that the inputs present.
  task automatic cycle();
    bit acc, del;
    acc = in_valid && (mq_sum.size() < 2);
    del = out_ready && (mq_sum.size() > 0);
    if (rst) begin
      mq_sum.delete();
      mq_tag.delete();
      m_count  = 16'd0;
      m_sticky = 4'd0;
    end else begin
      if (del) begin
        void'(mq_sum.pop_front());
        void'(mq_tag.pop_front());
        m_count = m_count + 16'd1;
      end
      if (acc) begin
        mq_sum.push_back(in_sum);
        mq_tag.push_back(in_tag);
        m_sticky = flags_clr ? ref_class(in_sum) : (m_sticky | ref_class(in_sum));
      end else if (flags_clr) begin
        m_sticky = 4'd0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flags_clr = 1'b0; in_sum = '0; in_tag = '0;
    cycle();
    cycle();
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (out_sum !== 64'd0) begin n_fail++; $display("FAIL reset_out_sum got=%h want=0", out_sum); end
    n_cmp++; if (out_tag !== 4'd0) begin n_fail++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
    n_cmp++; if (out_class !== 4'd0) begin n_fail++; $display("FAIL reset_out_class got=%b want=0000", out_class); end
    n_cmp++; if (sticky_flags !== 4'd0) begin n_fail++; $display("FAIL reset_sticky got=%b want=0000", sticky_flags); end
    n_cmp++; if (res_count !== 16'd0) begin n_fail++; $display("FAIL reset_res_count got=%0d want=0", res_count); end
    $display("reset: checked idle outputs");
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_sum = 64'h3FF0000000000000; in_tag = 4'd3; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency out_valid got=%b want=1", out_valid); end
    n_cmp++;
    if (out_sum !== 64'h3FF0000000000000 || out_tag !== 4'd3 || out_class !== ref_class(64'h3FF0000000000000)) begin
      n_fail++;
      $display("FAIL single_head got=%h/%h/%b want=3ff0000000000000/3/%b", out_sum, out_tag, out_class,
               ref_class(64'h3FF0000000000000));
    end
    cycle();
    n_cmp++; if (res_count !== m_count) begin n_fail++; $display("FAIL single_count got=%0d want=%0d", res_count, m_count); end
    $display("single: push 1.0 tag 3, count=%0d", res_count);
  endtask

  task automatic test_back_to_back();
    logic [63:0] vals[3];
    int idx = 0;
    bit acc;
    vals[0] = 64'h7FF0000000000000;
    vals[1] = 64'h7FF8000000000000;
    vals[2] = 64'h8000000000000000;
    for (int c = 0; c < 12 && !(idx == 3 && mq_sum.size() == 0); c++) begin
      in_valid  = (idx < 3);
      in_sum    = vals[(idx < 3) ? idx : 2];
      in_tag    = 4'(idx + 8);
      out_ready = (c >= 4);
      n_cmp++;
      if (in_ready !== (mq_sum.size() < 2) || out_valid !== (mq_sum.size() > 0)) begin
        n_fail++;
        $display("FAIL b2b_hs cyc=%0d got rdy=%b vld=%b want rdy=%b vld=%b", c, in_ready, out_valid,
                 mq_sum.size() < 2, mq_sum.size() > 0);
      end
      if (c == 2) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full in_ready got=%b want=0", in_ready); end
      end
      if (out_ready && mq_sum.size() > 0) begin
        n_cmp++;
        if (out_sum !== mq_sum[0] || out_tag !== mq_tag[0] || out_class !== ref_class(mq_sum[0])) begin
          n_fail++;
          $display("FAIL b2b_order got=%h/%h/%b want=%h/%h/%b", out_sum, out_tag, out_class,
                   mq_sum[0], mq_tag[0], ref_class(mq_sum[0]));
        end
        $display("b2b: delivered %h class %b", out_sum, out_class);
      end
      acc = in_valid && (mq_sum.size() < 2);
      cycle();
      if (acc) idx++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0; in_valid = 1'b1;
    in_sum = rand_val(); in_tag = 4'd1; cycle();
    in_sum = rand_val(); in_tag = 4'd2; cycle();
    n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL rstfull_pre got rdy=%b vld=%b want 0/1", in_ready, out_valid); end
    rst = 1'b1;
    cycle();
    rst = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rstfull_hs got vld=%b rdy=%b want 0/1", out_valid, in_ready); end
    n_cmp++; if (res_count !== 16'd0) begin n_fail++; $display("FAIL rstfull_count got=%0d want=0", res_count); end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstfull_stale cyc=%0d out_valid got=%b want=0", c, out_valid); end
      cycle();
    end
    $display("reset_full: buffer dropped, count=%0d", res_count);
  endtask

  task automatic test_stream(input int n, input bit rand_ready);
    int idx = 0;
    bit acc;
    logic [63:0] nxt;
    logic [15:0] start;
    start = m_count;
    nxt = rand_val();
    for (int c = 0; c < 4 * n + 20 && !(idx == n && mq_sum.size() == 0); c++) begin
      in_valid  = (idx < n);
      in_sum    = nxt;
      in_tag    = 4'(idx);
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      n_cmp++;
      if (in_ready !== (mq_sum.size() < 2) || out_valid !== (mq_sum.size() > 0)) begin
        n_fail++;
        $display("FAIL stream_hs cyc=%0d got rdy=%b vld=%b want rdy=%b vld=%b", c, in_ready, out_valid,
                 mq_sum.size() < 2, mq_sum.size() > 0);
      end
      n_cmp++; if (res_count !== m_count) begin n_fail++; $display("FAIL stream_count cyc=%0d got=%0d want=%0d", c, res_count, m_count); end
      if (out_ready && mq_sum.size() > 0) begin
        n_cmp++;
        if (out_sum !== mq_sum[0] || out_tag !== mq_tag[0] || out_class !== ref_class(mq_sum[0])) begin
          n_fail++;
          $display("FAIL stream_data got=%h/%h/%b want=%h/%h/%b", out_sum, out_tag, out_class,
                   mq_sum[0], mq_tag[0], ref_class(mq_sum[0]));
        end
      end
      acc = in_valid && (mq_sum.size() < 2);
      cycle();
      if (acc) begin
        idx++;
        nxt = rand_val();
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (res_count !== 16'(start + 16'(n))) begin n_fail++; $display("FAIL stream_total got=%0d want=%0d", res_count, 16'(start + 16'(n))); end
    $display("stream: n=%0d random_ready=%0b count=%0d", n, rand_ready, res_count);
  endtask

  task automatic test_flags();
    rst = 1'b1; cycle(); rst = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_sum = 64'h1; in_tag = 4'd1;
    cycle();
    in_valid = 1'b0;
    n_cmp++; if (sticky_flags !== m_sticky) begin n_fail++; $display("FAIL flags_sub got=%b want=%b", sticky_flags, m_sticky); end
    flags_clr = 1'b1;
    cycle();
    flags_clr = 1'b0;
    n_cmp++; if (sticky_flags !== 4'b0000) begin n_fail++; $display("FAIL flags_clr got=%b want=0000", sticky_flags); end
    in_valid = 1'b1; in_sum = 64'h1;
    cycle();
    in_sum = 64'h7FF0000000000000; flags_clr = 1'b1;
    cycle();
    flags_clr = 1'b0;
    n_cmp++; if (sticky_flags !== m_sticky) begin n_fail++; $display("FAIL flags_clr_accept got=%b want=%b", sticky_flags, m_sticky); end
    in_sum = 64'h8000000000000000;
    cycle();
    in_valid = 1'b0;
    n_cmp++; if (sticky_flags !== m_sticky) begin n_fail++; $display("FAIL flags_or got=%b want=%b", sticky_flags, m_sticky); end
    cycle();
    cycle();
    $display("flags: sticky=%b", sticky_flags);
  endtask

  task automatic test_wrap();
    rst = 1'b1; cycle(); rst = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 70000 && m_count != 16'hFFFF; c++) begin
      in_sum = {$urandom, $urandom};
      cycle();
    end
    in_valid = 1'b0;
    n_cmp++; if (res_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_max got=%h want=ffff", res_count); end
    cycle();
    n_cmp++; if (res_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero got=%h want=0000", res_count); end
    $display("wrap: count after 65536 deliveries=%h", res_count);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flags_clr = 1'b0; in_sum = '0; in_tag = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_full();
    test_stream(100, 1'b0);
    test_stream(200, 1'b1);
    test_flags();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
